// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit owning HI/LO; multi-cycle MULT/MULTU/DIV/DIVU, MFHI/MFLO/MTHI/MTLO.
//   clk    : clock, all state updates on posedge
//   rst    : asynchronous active-low reset
//   flush  : synchronous cancel of the in-flight op; HI/LO untouched
//   op     : 0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI,8 MTLO, 9-15 NONE
//   A, B   : rs / rt operands
//   busy   : multi-cycle op in flight
//   mf_out : HI for MFHI, LO for MFLO, else 0
//   hi, lo : committed HI/LO
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] mf_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic [31:0]   r_hi, r_lo, r_tmp_hi, r_tmp_lo;
  logic          w_start, w_mul, w_sdiv;
  logic [31:0]   w_da, w_db, w_q, w_r, w_hi, w_lo;
  logic [63:0]   w_prod;
  assign w_start = !r_busy && op >= 4'd1 && op <= 4'd4;
  assign w_mul   = op <= 4'd2;
  assign w_sdiv  = op == 4'd3;
  // one shared unsigned multiplier: MULT sign-extends its operands, low 64 bits are the signed product
  assign w_prod  = {{32{op == 4'd1 && A[31]}}, A} * {{32{op == 4'd1 && B[31]}}, B};
  // one shared unsigned divider on magnitudes; signs restored afterwards for DIV
  assign w_da = w_sdiv && A[31] ? -A : A;
  assign w_db = w_sdiv && B[31] ? -B : B;
  assign w_q  = w_db == 32'd0 ? 32'd0 : w_da / w_db;
  assign w_r  = w_db == 32'd0 ? 32'd0 : w_da % w_db;
  // divide by zero latches the current HI/LO so completion leaves them unchanged
  assign w_hi = w_mul ? w_prod[63:32] : B == 32'd0 ? r_hi : w_sdiv && A[31] ? -w_r : w_r;
  assign w_lo = w_mul ? w_prod[31:0] : B == 32'd0 ? r_lo : w_sdiv && (A[31] ^ B[31]) ? -w_q : w_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_tmp_hi <= '0;
      r_tmp_lo <= '0;
    end else if (flush) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_tmp_hi <= '0;
      r_tmp_lo <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        r_hi   <= r_tmp_hi;
        r_lo   <= r_tmp_lo;
      end
    end else if (w_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= w_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      r_tmp_hi <= w_hi;
      r_tmp_lo <= w_lo;
    end else begin
      if (op == 4'd7) r_hi <= A;
      if (op == 4'd8) r_lo <= A;
    end
  end
  assign busy   = r_busy;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign mf_out = op == 4'd5 ? r_hi : op == 4'd6 ? r_lo : 32'd0;
endmodule
